// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - IR fields, memory handshake and datapath controls of the multi-cycle MIPS controller
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic [1:0] PCSource;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtOp;
    logic [3:0] ALUControl;
    logic [2:0] BranchSt;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, rt, mem_ready,
        output PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ExtOp, ALUControl,
               BranchSt, instr_done, illegal, state
    );

    modport slave (
        output opcode, funct, rt, mem_ready,
        input  PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ExtOp, ALUControl,
               BranchSt, instr_done, illegal, state
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS controller FSM sequencing ALU, memory, register file and PC
module multicycle_control #(
    parameter int RESET_PC_HOLD = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_control_if.master   bus
);
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_EXEC_I   = 4'd8,
        S_ALU_WB   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JUMPR    = 4'd12
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_NOR  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

    state_t     state_q, state_d;
    logic [3:0] idle_cnt_q, idle_cnt_d;

    logic dec_r_alu, dec_jr, dec_imm, dec_mem, dec_branch, dec_jump;

    always_comb begin
        dec_r_alu  = (bus.opcode == 6'h00) &&
                     ((bus.funct inside {[6'h20:6'h27]}) || bus.funct == 6'h2a || bus.funct == 6'h2b);
        dec_jr     = (bus.opcode == 6'h00) && (bus.funct == 6'h08);
        dec_imm    = bus.opcode inside {[6'h08:6'h0e]};
        dec_mem    = (bus.opcode == 6'h23) || (bus.opcode == 6'h2b);
        dec_branch = (bus.opcode inside {[6'h04:6'h07]}) ||
                     ((bus.opcode == 6'h01) && (bus.rt == 5'd0 || bus.rt == 5'd1));
        dec_jump   = (bus.opcode == 6'h02);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idle_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        idle_cnt_d      = idle_cnt_q;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.PCSource    = 2'd0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'd0;
        bus.ExtOp       = 1'b1;
        bus.ALUControl  = 4'd0;
        bus.BranchSt    = 3'd0;
        bus.instr_done  = 1'b0;
        bus.illegal     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (idle_cnt_q == HOLD_LAST) state_d = S_FETCH;
                else                         idle_cnt_d = idle_cnt_q + 4'd1;
            end
            S_FETCH: begin
                bus.MemRead    = 1'b1;
                bus.ALUSrcB    = 2'd1;
                bus.ALUControl = ALU_ADD;
                // IR and PC+4 are captured only in the cycle memory delivers the word
                bus.IRWrite    = bus.mem_ready;
                bus.PCWrite    = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.ALUSrcB    = 2'd3;
                bus.ALUControl = ALU_ADD;
                if (dec_r_alu)       state_d = S_EXEC_R;
                else if (dec_jr)     state_d = S_JUMPR;
                else if (dec_imm)    state_d = S_EXEC_I;
                else if (dec_mem)    state_d = S_MEM_ADDR;
                else if (dec_branch) state_d = S_BRANCH;
                else if (dec_jump)   state_d = S_JUMP;
                else begin
                    bus.illegal    = 1'b1;
                    bus.instr_done = 1'b1;
                    state_d        = S_FETCH;
                end
            end
            S_EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                case (bus.funct)
                    6'h20, 6'h21: bus.ALUControl = ALU_ADD;
                    6'h22, 6'h23: bus.ALUControl = ALU_SUB;
                    6'h24:        bus.ALUControl = ALU_AND;
                    6'h25:        bus.ALUControl = ALU_OR;
                    6'h26:        bus.ALUControl = ALU_XOR;
                    6'h27:        bus.ALUControl = ALU_NOR;
                    6'h2a:        bus.ALUControl = ALU_SLT;
                    6'h2b:        bus.ALUControl = ALU_SLTU;
                    default:      bus.ALUControl = 4'd0;
                endcase
                state_d = S_ALU_WB;
            end
            S_EXEC_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'd2;
                bus.ExtOp   = !(bus.opcode inside {[6'h0c:6'h0e]});
                case (bus.opcode)
                    6'h08, 6'h09: bus.ALUControl = ALU_ADD;
                    6'h0a:        bus.ALUControl = ALU_SLT;
                    6'h0b:        bus.ALUControl = ALU_SLTU;
                    6'h0c:        bus.ALUControl = ALU_AND;
                    6'h0d:        bus.ALUControl = ALU_OR;
                    6'h0e:        bus.ALUControl = ALU_XOR;
                    default:      bus.ALUControl = 4'd0;
                endcase
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                bus.RegWrite   = 1'b1;
                bus.RegDst     = (bus.opcode == 6'h00);
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_ADDR: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 2'd2;
                bus.ALUControl = ALU_ADD;
                state_d        = (bus.opcode == 6'h2b) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                bus.RegWrite   = 1'b1;
                bus.MemtoReg   = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_WR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.mem_ready) begin
                    bus.instr_done = 1'b1;
                    state_d        = S_FETCH;
                end
            end
            S_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUControl  = ALU_SUB;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'd1;
                case (bus.opcode)
                    6'h04:   bus.BranchSt = 3'd3;
                    6'h05:   bus.BranchSt = 3'd0;
                    6'h06:   bus.BranchSt = 3'd2;
                    6'h07:   bus.BranchSt = 3'd1;
                    6'h01:   bus.BranchSt = (bus.rt == 5'd1) ? 3'd5 : 3'd4;
                    default: bus.BranchSt = 3'd0;
                endcase
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_JUMP: begin
                bus.PCWrite    = 1'b1;
                bus.PCSource   = 2'd2;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_JUMPR: begin
                bus.PCWrite    = 1'b1;
                bus.PCSource   = 2'd3;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.state = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control against a per-instruction script model
module tb_multicycle_control;
    localparam int HOLD = 1;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcs;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       m2r;
        logic       rdst;
        logic       rw;
        logic       asa;
        logic [1:0] asb;
        logic       ext;
        logic [3:0] aluc;
        logic [2:0] bst;
        logic       done;
        logic       ill;
    } ctl_t;

    typedef struct {
        ctl_t       e;
        bit         mr;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
    } step_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if bus ();
    multicycle_control #(.RESET_PC_HOLD(HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    step_t q[$];
    ctl_t  exp_cur;
    ctl_t  act;
    bit    chk_en = 1'b0;
    int    n_cmp = 0;
    int    n_bad = 0;

    assign act = {bus.state, bus.PCWrite, bus.PCWriteCond, bus.PCSource, bus.IorD,
                  bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                  bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ExtOp, bus.ALUControl,
                  bus.BranchSt, bus.instr_done, bus.illegal};

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (act !== exp_cur) begin
                n_bad++;
                $display("FAIL ctl t=%0t got st=%0d vec=%h want st=%0d vec=%h",
                         $time, act.st, act, exp_cur.st, exp_cur);
            end
        end
    end

    task automatic chk(input string nm, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", nm, a, e);
        end
    endtask

    function automatic ctl_t base(input int st);
        ctl_t c = '0;
        c.st  = 4'(st);
        c.ext = 1'b1;
        return c;
    endfunction

    // instruction classes: 0 illegal, 1 R-ALU, 2 jr, 3 I-ALU, 4 load/store, 5 branch, 6 j
    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt);
        if (op == 6'h00) begin
            if ((fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2a || fn == 6'h2b) return 1;
            if (fn == 6'h08) return 2;
            return 0;
        end
        if (op >= 6'h08 && op <= 6'h0e) return 3;
        if (op == 6'h23 || op == 6'h2b) return 4;
        if (op >= 6'h04 && op <= 6'h07) return 5;
        if (op == 6'h01 && rt <= 5'd1) return 5;
        if (op == 6'h02) return 6;
        return 0;
    endfunction

    function automatic logic [3:0] alu_r(input logic [5:0] fn);
        case (fn)
            6'h20, 6'h21: return 4'd1;
            6'h22, 6'h23: return 4'd2;
            6'h24: return 4'd3;
            6'h25: return 4'd4;
            6'h26: return 4'd5;
            6'h27: return 4'd6;
            6'h2a: return 4'd8;
            default: return 4'd7;
        endcase
    endfunction

    function automatic logic [3:0] alu_i(input logic [5:0] op);
        case (op)
            6'h0a: return 4'd8;
            6'h0b: return 4'd7;
            6'h0c: return 4'd3;
            6'h0d: return 4'd4;
            6'h0e: return 4'd5;
            default: return 4'd1;
        endcase
    endfunction

    function automatic logic [2:0] bst_of(input logic [5:0] op, input logic [4:0] rt);
        case (op)
            6'h04: return 3'd3;
            6'h05: return 3'd0;
            6'h06: return 3'd2;
            6'h07: return 3'd1;
            default: return (rt == 5'd1) ? 3'd5 : 3'd4;
        endcase
    endfunction

    task automatic push(input ctl_t e, input bit mr, input logic [5:0] op,
                        input logic [5:0] fn, input logic [4:0] rt);
        step_t s;
        s.e = e; s.mr = mr; s.op = op; s.fn = fn; s.rt = rt;
        q.push_back(s);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push(base(0), 1'(($urandom_range(0, 1))), 6'h3f, 6'h3f, 5'd31);
    endtask

    // Appends the full expected cycle script of one instruction; fst/mst are memory stall counts.
    task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                             input int fst, input int mst);
        ctl_t e;
        int   k = kind_of(op, fn, rt);
        e = base(1); e.mrd = 1; e.asb = 2'd1; e.aluc = 4'd1;
        for (int i = 0; i < fst; i++)
            push(e, 1'b0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)));
        e.irw = 1; e.pcw = 1;
        push(e, 1'b1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)));
        e = base(2); e.asb = 2'd3; e.aluc = 4'd1;
        if (k == 0) begin e.ill = 1; e.done = 1; end
        push(e, 1'($urandom_range(0, 1)), op, fn, rt);
        case (k)
            1, 3: begin
                e = base(k == 1 ? 7 : 8); e.asa = 1;
                e.asb  = (k == 1) ? 2'd0 : 2'd2;
                e.aluc = (k == 1) ? alu_r(fn) : alu_i(op);
                e.ext  = (k == 3 && op >= 6'h0c && op <= 6'h0e) ? 1'b0 : 1'b1;
                push(e, 1'($urandom_range(0, 1)), op, fn, rt);
                e = base(9); e.rw = 1; e.rdst = (op == 6'h00); e.done = 1;
                push(e, 1'($urandom_range(0, 1)), op, fn, rt);
            end
            2: begin
                e = base(12); e.pcw = 1; e.pcs = 2'd3; e.done = 1;
                push(e, 1'($urandom_range(0, 1)), op, fn, rt);
            end
            4: begin
                e = base(3); e.asa = 1; e.asb = 2'd2; e.aluc = 4'd1;
                push(e, 1'($urandom_range(0, 1)), op, fn, rt);
                e = base(op == 6'h23 ? 4 : 6); e.iord = 1;
                if (op == 6'h23) e.mrd = 1; else e.mwr = 1;
                for (int i = 0; i < mst; i++) push(e, 1'b0, op, fn, rt);
                if (op == 6'h2b) e.done = 1;
                push(e, 1'b1, op, fn, rt);
                if (op == 6'h23) begin
                    e = base(5); e.rw = 1; e.m2r = 1; e.done = 1;
                    push(e, 1'($urandom_range(0, 1)), op, fn, rt);
                end
            end
            5: begin
                e = base(10); e.asa = 1; e.aluc = 4'd2; e.pcwc = 1; e.pcs = 2'd1;
                e.bst = bst_of(op, rt); e.done = 1;
                push(e, 1'($urandom_range(0, 1)), op, fn, rt);
            end
            6: begin
                e = base(11); e.pcw = 1; e.pcs = 2'd2; e.done = 1;
                push(e, 1'($urandom_range(0, 1)), op, fn, rt);
            end
            default: ;
        endcase
    endtask

    // Plays up to lim script steps; inputs change 1 time unit after the rising edge.
    task automatic run_q(input int lim);
        step_t s;
        int    n = 0;
        while (q.size() > 0 && n < lim) begin
            s = q.pop_front();
            bus.mem_ready = s.mr;
            bus.opcode    = s.op;
            bus.funct     = s.fn;
            bus.rt        = s.rt;
            exp_cur       = s.e;
            chk_en        = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        chk_en = 1'b0;
    endtask

    task automatic state_seq(input string nm, input int exp_states[$]);
        chk({nm, "_len"}, q.size(), exp_states.size());
        for (int i = 0; i < exp_states.size() && i < q.size(); i++)
            chk(nm, int'(q[i].e.st), exp_states[i]);
    endtask

    initial begin
        logic [5:0] op, fn;
        logic [4:0] rt;
        int         pick;
        bus.mem_ready = 1'b0;
        bus.opcode = 6'h0; bus.funct = 6'h0; bus.rt = 5'd0;
        @(posedge clk);
        #1;

        // model pins
        add_instr(6'h00, 6'h2a, 5'd0, 0, 0);
        state_seq("seq_rtype", '{1, 2, 7, 9});
        chk("slt_aluc", int'(q[2].e.aluc), 8);
        q.delete();
        add_instr(6'h23, 6'h00, 5'd0, 0, 2);
        state_seq("seq_lw_stall", '{1, 2, 3, 4, 4, 4, 5});
        q.delete();
        add_instr(6'h2b, 6'h00, 5'd0, 0, 0);
        chk("len_sw", q.size(), 4);
        q.delete();
        add_instr(6'h01, 6'h00, 5'd1, 0, 0);
        chk("len_bgez", q.size(), 3);
        chk("bgez_bst", int'(q[2].e.bst), 5);
        q.delete();

        // reset and IDLE
        push_idle(3);
        run_q(3);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_ext", int'(bus.ExtOp), 1);
        rst_n = 1'b1;
        push_idle(HOLD);

        // directed
        add_instr(6'h00, 6'h2a, 5'd0, 0, 0);
        add_instr(6'h23, 6'h00, 5'd3, 1, 2);
        add_instr(6'h01, 6'h00, 5'd1, 0, 0);
        add_instr(6'h02, 6'h00, 5'd0, 0, 0);
        add_instr(6'h00, 6'h08, 5'd0, 0, 0);
        add_instr(6'h0d, 6'h00, 5'd0, 0, 0);
        add_instr(6'h3f, 6'h00, 5'd0, 0, 0);
        add_instr(6'h2b, 6'h00, 5'd0, 0, 2);
        run_q(q.size());

        // randomized
        for (int n = 0; n < 400; n++) begin
            pick = $urandom_range(0, 9);
            fn = 6'($urandom_range(0, 63));
            rt = 5'($urandom_range(0, 3));
            case (pick)
                0, 1: begin
                    op = 6'h00;
                    if ($urandom_range(0, 3) != 0) fn = 6'($urandom_range(32, 43));
                    else if ($urandom_range(0, 1) == 1) fn = 6'h08;
                end
                2, 3: op = 6'($urandom_range(8, 14));
                4:    op = ($urandom_range(0, 1) == 1) ? 6'h23 : 6'h2b;
                5:    op = 6'($urandom_range(4, 7));
                6:    op = 6'h01;
                7:    op = 6'h02;
                default: op = 6'($urandom_range(0, 63));
            endcase
            add_instr(op, fn, rt, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
            run_q(q.size());
        end

        // reset in the middle of a store stall
        add_instr(6'h2b, 6'h00, 5'd0, 0, 3);
        run_q(4);
        q.delete();
        bus.mem_ready = 1'b0;
        #1;
        chk("sw_stall_memwrite", int'(bus.MemWrite), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_memwrite", int'(bus.MemWrite), 0);
        chk("midrst_state", int'(bus.state), 0);
        push_idle(2);
        run_q(2);
        rst_n = 1'b1;
        push_idle(HOLD);
        add_instr(6'h00, 6'h20, 5'd0, 0, 0);
        run_q(q.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
